// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_pkg
//  Description : Shared FSM encoding, field widths and address check for the
//                instruction fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [PC_W-1:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        HALT  = 2'd2
    } if_state_e;

    // Word aligned and low enough that all four bytes lie inside memory.
    function automatic logic addr_legal(input logic [PC_W-1:0] addr,
                                        input logic [PC_W-1:0] max_addr);
        return (addr[1:0] == 2'b00) && (addr <= max_addr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_buffer
//  Description : One-entry holder for a fetched pc/pc4/instr while decode stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buffer
    import instruction_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [PC_W-1:0]    pc4_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               valid_o,
    output logic [PC_W-1:0]    pc_o,
    output logic [PC_W-1:0]    pc4_o,
    output logic [INSTR_W-1:0] instr_o
);

    logic               valid_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc4_q;
    logic [INSTR_W-1:0] instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            pc4_q   <= '0;
            instr_q <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            pc4_q   <= pc4_i;
            instr_q <= instr_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch
//  Description : Single-issue fetch stage with IF/ID register, skid buffer,
//                redirect handling and sticky fetch-fault halt.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        fetch_fault
);

    localparam logic [PC_W-1:0] MAX_ADDR = 32'(IMEM_BYTES) - INSTR_BYTES;

    if_state_e          state_q;
    logic [PC_W-1:0]    pc_q;
    logic               ifid_valid_q;
    logic [PC_W-1:0]    ifid_pc_q;
    logic [PC_W-1:0]    ifid_pc4_q;
    logic [INSTR_W-1:0] ifid_instr_q;
    logic               fault_q;

    logic               pc_legal;
    logic               redirect_legal;
    logic [PC_W-1:0]    pc_plus4;
    logic               accept;
    logic               skid_load;
    logic               skid_clear;
    logic               skid_valid;
    logic [PC_W-1:0]    skid_pc;
    logic [PC_W-1:0]    skid_pc4;
    logic [INSTR_W-1:0] skid_instr;

    assign pc_legal       = addr_legal(pc_q, MAX_ADDR);
    assign redirect_legal = addr_legal(redirect_pc, MAX_ADDR);
    assign pc_plus4       = pc_q + INSTR_BYTES;

    // rst_n gates the request so nothing is issued while reset is held.
    assign imem_req  = rst_n && (state_q == FETCH) && pc_legal;
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_valid;

    assign skid_load  = accept && stall && !redirect;
    assign skid_clear = redirect || ((state_q == FULL) && !stall);

    fetch_skid_buffer u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .pc_i    (pc_q),
        .pc4_i   (pc_plus4),
        .instr_i (imem_rdata),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .pc4_o   (skid_pc4),
        .instr_o (skid_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= '0;
            fault_q      <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (redirect) begin
                        pc_q         <= redirect_pc;
                        ifid_valid_q <= 1'b0;
                    end else if (!pc_legal) begin
                        fault_q <= 1'b1;
                        state_q <= HALT;
                        if (!stall) ifid_valid_q <= 1'b0;
                    end else if (accept) begin
                        pc_q <= pc_plus4;
                        if (!stall) begin
                            ifid_valid_q <= 1'b1;
                            ifid_pc_q    <= pc_q;
                            ifid_pc4_q   <= pc_plus4;
                            ifid_instr_q <= imem_rdata;
                        end else begin
                            state_q <= FULL;
                        end
                    end else if (!stall) begin
                        ifid_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (redirect) begin
                        pc_q         <= redirect_pc;
                        ifid_valid_q <= 1'b0;
                        state_q      <= FETCH;
                    end else if (!stall && skid_valid) begin
                        ifid_valid_q <= 1'b1;
                        ifid_pc_q    <= skid_pc;
                        ifid_pc4_q   <= skid_pc4;
                        ifid_instr_q <= skid_instr;
                        state_q      <= FETCH;
                    end
                end
                HALT: begin
                    if (redirect) begin
                        ifid_valid_q <= 1'b0;
                        if (redirect_legal) begin
                            pc_q    <= redirect_pc;
                            fault_q <= 1'b0;
                            state_q <= FETCH;
                        end
                    end else if (!stall) begin
                        ifid_valid_q <= 1'b0;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign if_id_valid = ifid_valid_q;
    assign if_id_pc    = ifid_pc_q;
    assign if_id_pc4   = ifid_pc4_q;
    assign if_id_instr = ifid_instr_q;
    assign fetch_fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch
//  Description : Directed table-driven bench for instruction_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        fetch_fault;
    logic        mem_en;

    int errors = 0;
    int checks = 0;

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (60)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .if_id_valid (if_id_valid),
        .if_id_pc    (if_id_pc),
        .if_id_pc4   (if_id_pc4),
        .if_id_instr (if_id_instr),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: byte at address x is x[7:0] ^ 8'h5A, words are big-endian.
    function automatic logic [7:0] mem_byte(input logic [31:0] x);
        return x[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a), mem_byte(a + 32'd1), mem_byte(a + 32'd2), mem_byte(a + 32'd3)};
    endfunction

    assign imem_valid = imem_req && mem_en;
    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic ev, input logic [31:0] epc);
        chk({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, ev});
        if (ev) begin
            chk({tag, " pc"},    if_id_pc,    epc);
            chk({tag, " pc4"},   if_id_pc4,   epc + 32'd4);
            chk({tag, " instr"}, if_id_instr, mem_word(epc));
        end
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] rpc, input logic en);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        mem_en      = en;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        en;
        logic        ev;
        logic [31:0] epc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        efault;
    } vec_t;

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 1'b1, 32'h08, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0C, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0C, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0C, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0C, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h10, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b1, 32'h10, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b1, 32'h10, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h10, 1'b1, 32'h14, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 32'h00, 1'b1, 32'h20, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h20, 1'b1, 32'h24, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'h22, 1'b1, 1'b0, 32'h00, 1'b0, 32'h22, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b0, 32'h22, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 1'b0, 32'h22, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04, 1'b0};

        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_en      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req",   {31'd0, imem_req},    32'd0);
        chk("reset valid", {31'd0, if_id_valid}, 32'd0);
        chk("reset pc",    if_id_pc,             32'd0);
        chk("reset pc4",   if_id_pc4,            32'd0);
        chk("reset instr", if_id_instr,          32'd0);
        chk("reset fault", {31'd0, fetch_fault}, 32'd0);

        rst_n = 1'b1;
        #1;
        chk("first req",  {31'd0, imem_req}, 32'd1);
        chk("first addr", imem_addr,         32'd0);
        @(posedge clk);
        #1;
        chk_ifid("first load", 1'b1, 32'h0);
        chk("first next addr", imem_addr, 32'h4);

        // Restart cleanly so the table starts from a known reset state.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].en);
            chk_ifid($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc);
            chk($sformatf("vec%0d req", i),   {31'd0, imem_req},    {31'd0, vecs[i].ereq});
            chk($sformatf("vec%0d addr", i),  imem_addr,            vecs[i].eaddr);
            chk($sformatf("vec%0d fault", i), {31'd0, fetch_fault}, {31'd0, vecs[i].efault});
        end

        // Run sequentially into the end of memory: 56 is the last legal word.
        for (int k = 1; k <= 14; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            chk_ifid($sformatf("seq%0d", k), 1'b1, 32'(4 * k));
        end
        chk("end req",   {31'd0, imem_req},    32'd0);
        chk("end addr",  imem_addr,            32'd60);
        chk("end fault", {31'd0, fetch_fault}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("halt valid", {31'd0, if_id_valid}, 32'd0);
        chk("halt fault", {31'd0, fetch_fault}, 32'd1);
        chk("halt req",   {31'd0, imem_req},    32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("halt stays", {31'd0, fetch_fault}, 32'd1);
        step(1'b0, 1'b1, 32'h0, 1'b1);
        chk("recover fault", {31'd0, fetch_fault}, 32'd0);
        chk("recover req",   {31'd0, imem_req},    32'd1);
        chk("recover addr",  imem_addr,            32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk_ifid("resume0", 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk_ifid("resume4", 1'b1, 32'h4);

        // Enter FULL (IF/ID holds pc 4, skid holds pc 8), then reset mid-cycle.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("full req", {31'd0, imem_req}, 32'd0);
        chk_ifid("full hold", 1'b1, 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async valid", {31'd0, if_id_valid}, 32'd0);
        chk("async pc",    if_id_pc,             32'd0);
        chk("async pc4",   if_id_pc4,            32'd0);
        chk("async instr", if_id_instr,          32'd0);
        chk("async req",   {31'd0, imem_req},    32'd0);
        chk("async addr",  imem_addr,            32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post reset req",  {31'd0, imem_req}, 32'd1);
        chk("post reset addr", imem_addr,         32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk_ifid("post reset load", 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk_ifid("post reset next", 1'b1, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
